alu_share_arbiter: RTL and testbench

//   Shares one ALU instance between two requesters (e.g. main datapath and a

---
 rtl/alu_share_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//
// Purpose:
//   Lets two requesters share one external ALU. Requests are arbitrated
//   round-robin. Operands are registered toward the ALU, and the result and
//   Zero flag are registered back. Only one transaction is in flight at a time.
//
// Optional feature (macro ALU_ARB_OPCHECK_EN):
//   When defined, op codes 8..15 are illegal. An illegal op bypasses the ALU,
//   which leaves the alu_* registers unchanged. It answers one cycle after
//   accept with rsp_result=0, rsp_zero=1 and rsp_err=1.
//   When undefined, every op is forwarded to the ALU and rsp_err is tied 0.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid_i / req_ready_i  request handshake per requester (ready is comb.)
//   req_op_i/a_i/b_i/shamt_i   request payload per requester
//   rsp_valid_i / rsp_ready_i  response handshake per requester
//   rsp_result/zero/err        shared registered response bus
//   alu_op/a/b/shamt           registered operands to the ALU
//   alu_result/zero            ALU outputs, captured during EXEC
//
// State table:
//   IDLE | waiting for a request; grants one and latches its operands
//   EXEC | ALU evaluating the latched operands; result captured at cycle end
//   RESP | response presented to the granted requester until it is consumed
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_0,
  input  logic                  req_valid_1,
  output logic                  req_ready_0,
  output logic                  req_ready_1,
  input  logic [OP_WIDTH-1:0]   req_op_0,
  input  logic [OP_WIDTH-1:0]   req_op_1,
  input  logic [DATA_WIDTH-1:0] req_a_0,
  input  logic [DATA_WIDTH-1:0] req_a_1,
  input  logic [DATA_WIDTH-1:0] req_b_0,
  input  logic [DATA_WIDTH-1:0] req_b_1,
  input  logic [4:0]            req_shamt_0,
  input  logic [4:0]            req_shamt_1,
  output logic                  rsp_valid_0,
  output logic                  rsp_valid_1,
  input  logic                  rsp_ready_0,
  input  logic                  rsp_ready_1,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_err,
  output logic [OP_WIDTH-1:0]   alu_op,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [4:0]            alu_shamt,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                  last_grant_q;
  logic                  grant_id_q;
  logic                  grant_sel;
  logic                  accept;
  logic                  rsp_hs;
  logic                  op_illegal;
  logic [OP_WIDTH-1:0]   sel_op;
  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;
  logic [4:0]            sel_shamt;
  logic [DATA_WIDTH-1:0] rsp_result_q;
  logic                  rsp_zero_q;
  logic [OP_WIDTH-1:0]   alu_op_q;
  logic [DATA_WIDTH-1:0] alu_a_q;
  logic [DATA_WIDTH-1:0] alu_b_q;
  logic [4:0]            alu_shamt_q;

`ifdef ALU_ARB_OPCHECK_EN
  logic                  rsp_err_q;
`endif

  // Arbitration and request-side handshake
  always_comb begin
    // On a tie the requester that was not served last wins. A single request
    // wins whichever side it comes from.
    if (req_valid_0 && req_valid_1) begin
      grant_sel = ~last_grant_q;
    end else begin
      grant_sel = req_valid_1;
    end

    sel_op    = grant_sel ? req_op_1    : req_op_0;
    sel_a     = grant_sel ? req_a_1     : req_a_0;
    sel_b     = grant_sel ? req_b_1     : req_b_0;
    sel_shamt = grant_sel ? req_shamt_1 : req_shamt_0;

    // Readiness is held off during reset so no handshake completes while
    // the state register is being cleared.
    accept = (state_q == IDLE) && (req_valid_0 || req_valid_1) && !reset;

    req_ready_0 = accept && !grant_sel;
    req_ready_1 = accept &&  grant_sel;

`ifdef ALU_ARB_OPCHECK_EN
    op_illegal = (sel_op > OP_WIDTH'(7));
`else
    op_illegal = 1'b0;
`endif
  end

  // Response-side handshake
  always_comb begin
    rsp_valid_0 = (state_q == RESP) && !grant_id_q && !reset;
    rsp_valid_1 = (state_q == RESP) &&  grant_id_q && !reset;
    rsp_hs      = (rsp_valid_0 && rsp_ready_0) || (rsp_valid_1 && rsp_ready_1);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = op_illegal ? RESP : EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        if (rsp_hs) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_shamt_q  <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        grant_id_q <= grant_sel;
        // An illegal op never reaches the ALU. Its canned response is
        // written straight into the response registers.
        if (op_illegal) begin
          rsp_result_q <= '0;
          rsp_zero_q   <= 1'b1;
        end else begin
          alu_op_q    <= sel_op;
          alu_a_q     <= sel_a;
          alu_b_q     <= sel_b;
          alu_shamt_q <= sel_shamt;
        end
      end

      if (state_q == EXEC) begin
        rsp_result_q <= alu_result;
        rsp_zero_q   <= alu_zero;
      end

      if (rsp_hs) begin
        last_grant_q <= grant_id_q;
      end
    end
  end

`ifdef ALU_ARB_OPCHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_err_q <= 1'b0;
    end else if (accept) begin
      rsp_err_q <= op_illegal;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign alu_op     = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_shamt  = alu_shamt_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Purpose:
//   Directed bench for alu_share_arbiter. A small reference ALU drives
//   alu_result and alu_zero. Drivers push the hand-computed responses into
//   per-requester queues. A monitor pops those queues at each response
//   handshake, and also checks grant order and accept-to-valid latency.
//   Build with ALU_ARB_OPCHECK_EN defined to exercise the illegal-op path.
//
// Reference ALU op codes:
//   0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB, 5 SLL (b << shamt),
//   anything else returns all ones.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;

  logic        clk;
  logic        reset;
  logic        req_valid_0, req_valid_1;
  logic        req_ready_0, req_ready_1;
  logic [3:0]  req_op_0, req_op_1;
  logic [31:0] req_a_0, req_a_1, req_b_0, req_b_1;
  logic [4:0]  req_shamt_0, req_shamt_1;
  logic        rsp_valid_0, rsp_valid_1;
  logic        rsp_ready_0, rsp_ready_1;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_err;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_result;
  logic        alu_zero;

  alu_share_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_op_0(req_op_0), .req_op_1(req_op_1),
    .req_a_0(req_a_0), .req_a_1(req_a_1),
    .req_b_0(req_b_0), .req_b_1(req_b_1),
    .req_shamt_0(req_shamt_0), .req_shamt_1(req_shamt_1),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  // Reference ALU
  always_comb begin
    case (alu_op)
      4'd0:    alu_result = alu_a & alu_b;
      4'd1:    alu_result = alu_a | alu_b;
      4'd2:    alu_result = alu_a ^ alu_b;
      4'd3:    alu_result = alu_a + alu_b;
      4'd4:    alu_result = alu_a - alu_b;
      4'd5:    alu_result = alu_b << alu_shamt;
      default: alu_result = 32'hFFFF_FFFF;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic        err;
    int          lat;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  bit   grant_q[$];
  int   acc_log[$];
  int   acc_cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

`ifdef ALU_ARB_OPCHECK_EN
  localparam logic [31:0] ILL_RES  = 32'd0;
  localparam logic        ILL_ZERO = 1'b1;
  localparam logic        ILL_ERR  = 1'b1;
  localparam int          ILL_LAT  = 1;
`else
  localparam logic [31:0] ILL_RES  = 32'hFFFF_FFFF;
  localparam logic        ILL_ZERO = 1'b0;
  localparam logic        ILL_ERR  = 1'b0;
  localparam int          ILL_LAT  = 2;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: grant order, latency, response payload at each handshake
  initial begin
    bit pv0 = 0;
    bit pv1 = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        pv0 = 0;
        pv1 = 0;
      end else begin
        if (req_ready_0 && req_ready_1) fail_now("both req_ready high");
        if (req_ready_0 || req_ready_1) begin
          if (grant_q.size() == 0) fail_now("unexpected grant");
          else check("grant order", 32'(req_ready_1), 32'(grant_q.pop_front()));
          acc_cyc = cyc;
          acc_log.push_back(cyc);
        end
        if (rsp_valid_0 && rsp_valid_1) fail_now("both rsp_valid high");
        if (rsp_valid_0 && !pv0) begin
          if (exp_q0.size() == 0) fail_now("unexpected rsp_valid_0");
          else check("latency0", 32'(cyc - acc_cyc), 32'(exp_q0[0].lat));
        end
        if (rsp_valid_1 && !pv1) begin
          if (exp_q1.size() == 0) fail_now("unexpected rsp_valid_1");
          else check("latency1", 32'(cyc - acc_cyc), 32'(exp_q1[0].lat));
        end
        if (rsp_valid_0 && rsp_ready_0 && exp_q0.size() > 0) begin
          e = exp_q0.pop_front();
          check("result0", rsp_result, e.result);
          check("zero0", 32'(rsp_zero), 32'(e.zero));
          check("err0", 32'(rsp_err), 32'(e.err));
        end
        if (rsp_valid_1 && rsp_ready_1 && exp_q1.size() > 0) begin
          e = exp_q1.pop_front();
          check("result1", rsp_result, e.result);
          check("zero1", 32'(rsp_zero), 32'(e.zero));
          check("err1", 32'(rsp_err), 32'(e.err));
        end
        pv0 = rsp_valid_0;
        pv1 = rsp_valid_1;
      end
    end
  end

  // Drive one request (caller is at posedge+1); returns at posedge+1 after the
  // accepting edge with valid dropped.
  task automatic issue(input bit id, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh, input bit want,
                       input logic [31:0] er, input logic ez, input logic ee, input int lat);
    exp_t e;
    bit done = 0;
    e.result = er; e.zero = ez; e.err = ee; e.lat = lat;
    if (want) begin
      if (id) exp_q1.push_back(e);
      else    exp_q0.push_back(e);
    end
    if (id) begin
      req_valid_1 = 1'b1; req_op_1 = op; req_a_1 = a; req_b_1 = b; req_shamt_1 = sh;
    end else begin
      req_valid_0 = 1'b1; req_op_0 = op; req_a_0 = a; req_b_0 = b; req_shamt_0 = sh;
    end
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (id ? req_ready_1 : req_ready_0) begin
        @(posedge clk);
        #1;
        done = 1;
        break;
      end
    end
    if (!done) fail_now(id ? "timeout req_ready_1" : "timeout req_ready_0");
    if (id) req_valid_1 = 1'b0;
    else    req_valid_0 = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (exp_q0.size() == 0 && exp_q1.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) fail_now("timeout waiting for responses");
    @(posedge clk);
    #1;
  endtask

  task automatic stall_check();
    bit seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid_1) begin
        seen = 1;
        break;
      end
    end
    if (!seen) fail_now("timeout rsp_valid_1 stall");
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("stall rsp_valid_1", 32'(rsp_valid_1), 32'd1);
      check("stall rsp_result", rsp_result, 32'd16);
      check("stall req_ready_0", 32'(req_ready_0), 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready_1 = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_valid_0 = 1'b1; req_valid_1 = 1'b0;
    req_op_0 = '0; req_op_1 = '0; req_a_0 = '0; req_a_1 = '0;
    req_b_0 = '0; req_b_1 = '0; req_shamt_0 = '0; req_shamt_1 = '0;
    rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;

    // Reset state
    repeat (3) begin
      @(negedge clk);
      check("reset req_ready_0", 32'(req_ready_0), 32'd0);
    end
    req_valid_0 = 1'b0;
    @(negedge clk);
    check("reset rsp_valid_0", 32'(rsp_valid_0), 32'd0);
    check("reset rsp_valid_1", 32'(rsp_valid_1), 32'd0);
    check("reset rsp_result", rsp_result, 32'd0);
    check("reset rsp_zero", 32'(rsp_zero), 32'd0);
    check("reset rsp_err", 32'(rsp_err), 32'd0);
    check("reset alu_op", 32'(alu_op), 32'd0);
    check("reset alu_a", alu_a, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single ADD from requester 0
    grant_q.push_back(1'b0);
    issue(1'b0, 4'd3, 32'd5, 32'd7, 5'd0, 1'b1, 32'd12, 1'b0, 1'b0, 2);
    drain();

    // Simultaneous requests after reset: requester 0 wins the tie
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    grant_q.push_back(1'b0);
    grant_q.push_back(1'b1);
    fork
      issue(1'b0, 4'd4, 32'd9, 32'd9, 5'd0, 1'b1, 32'd0, 1'b1, 1'b0, 2);
      issue(1'b1, 4'd5, 32'd0, 32'd1, 5'd4, 1'b1, 32'd16, 1'b0, 1'b0, 2);
    join
    drain();

    // Both continuously valid: alternate 0,1,0,1 at 3-cycle spacing
    acc_log.delete();
    grant_q.push_back(1'b0); grant_q.push_back(1'b1);
    grant_q.push_back(1'b0); grant_q.push_back(1'b1);
    fork
      begin
        issue(1'b0, 4'd3, 32'd100, 32'd23, 5'd0, 1'b1, 32'd123, 1'b0, 1'b0, 2);
        issue(1'b0, 4'd2, 32'hFF, 32'h0F, 5'd0, 1'b1, 32'hF0, 1'b0, 1'b0, 2);
      end
      begin
        issue(1'b1, 4'd4, 32'd50, 32'd8, 5'd0, 1'b1, 32'd42, 1'b0, 1'b0, 2);
        issue(1'b1, 4'd0, 32'hF0F0, 32'h0FF0, 5'd0, 1'b1, 32'h00F0, 1'b0, 1'b0, 2);
      end
    join
    drain();
    check("accept count", 32'(acc_log.size()), 32'd4);
    for (int i = 1; i < acc_log.size(); i++)
      check("accept spacing", 32'(acc_log[i] - acc_log[i-1]), 32'd3);

    // Stalled response for requester 1 blocks requester 0
    rsp_ready_1 = 1'b0;
    grant_q.push_back(1'b1);
    grant_q.push_back(1'b0);
    issue(1'b1, 4'd3, 32'd10, 32'd6, 5'd0, 1'b1, 32'd16, 1'b0, 1'b0, 2);
    fork
      issue(1'b0, 4'd1, 32'hF0, 32'h0F, 5'd0, 1'b1, 32'hFF, 1'b0, 1'b0, 2);
      stall_check();
    join
    drain();

    // Reset during EXEC drops the transaction
    grant_q.push_back(1'b0);
    issue(1'b0, 4'd3, 32'd1, 32'd1, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post-reset rsp_valid_0", 32'(rsp_valid_0), 32'd0);
    check("post-reset rsp_valid_1", 32'(rsp_valid_1), 32'd0);
    check("post-reset rsp_result", rsp_result, 32'd0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    grant_q.push_back(1'b1);
    issue(1'b1, 4'd0, 32'hF0, 32'h3C, 5'd0, 1'b1, 32'h30, 1'b0, 1'b0, 2);
    drain();

    // Op code 0xC: illegal with the op check, forwarded to the ALU without it
    grant_q.push_back(1'b0);
    issue(1'b0, 4'hC, 32'd3, 32'd4, 5'd0, 1'b1, ILL_RES, ILL_ZERO, ILL_ERR, ILL_LAT);
    drain();
`ifdef ALU_ARB_OPCHECK_EN
    check("alu_op unchanged", 32'(alu_op), 32'd0);
    check("alu_a unchanged", alu_a, 32'hF0);
`else
    check("alu_op forwarded", 32'(alu_op), 32'hC);
    check("alu_a forwarded", alu_a, 32'd3);
`endif

    check("leftover exp_q0", 32'(exp_q0.size()), 32'd0);
    check("leftover exp_q1", 32'(exp_q1.size()), 32'd0);
    check("leftover grants", 32'(grant_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
